layer_priority_ctrl: RTL and testbench

- Owns the object-layer priority table and per-layer visibility for the VGA object mux.
- Game logic submits a new priority order, enable mask and blink mask over a valid/ready handshake.
- Updates are applied only on the frame boundary (startOfFrame), so the picture never tears mid-frame.
- Outputs (layerOrder, layerEnable) drive a programmable-priority object mux; background is always lowest priority and is not managed here.

---
 rtl/objects_pkg.sv | 23 ++
 rtl/order_perm_check.sv | 19 +
 rtl/layer_priority_ctrl.sv | 117 +++++++++++
 tb/tb_layer_priority_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/objects_pkg.sv
// Shared object-layer definitions for the VGA object mux and its priority controller.
package objects_pkg;

    localparam int NUM_LAYERS = 4;

    typedef enum logic [1:0] {
        LAYER_KONG     = 2'd0,
        LAYER_TARGET   = 2'd1,
        LAYER_ROPE     = 2'd2,
        LAYER_PLATFORM = 2'd3
    } layer_idx_t;

    // Slot 0 (bits [1:0]) holds the highest-priority layer index.
    typedef logic [NUM_LAYERS-1:0][1:0] layer_order_t;

    localparam layer_order_t DEFAULT_ORDER = 8'b11_10_01_00;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } ctrl_state_t;

endpackage

// File: rtl/order_perm_check.sv
// Combinational check that a priority order names every layer exactly once.
module order_perm_check
    import objects_pkg::*;
(
    input  layer_order_t order,
    output logic         isValid
);

    logic [NUM_LAYERS-1:0] seen;

    // With as many slots as layers, covering every index implies no duplicates.
    always_comb begin
        seen = '0;
        for (int s = 0; s < NUM_LAYERS; s++)
            seen[order[s]] = 1'b1;
        isValid = &seen;
    end

endmodule

// File: rtl/layer_priority_ctrl.sv
// Frame-aligned layer priority / visibility controller for the VGA object mux.
// Optional LAYER_SOLO_EN adds an immediate single-layer solo override.
module layer_priority_ctrl
    import objects_pkg::*;
#(
    parameter int BLINK_PERIOD = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            startOfFrame,
    input  logic                            cfgValid,
    output logic                            cfgReady,
    input  logic [7:0]                      cfgOrder,
    input  logic [NUM_LAYERS-1:0]           cfgEnableMask,
    input  logic [NUM_LAYERS-1:0]           cfgBlinkMask,
    output logic                            cfgError,
    output logic                            cfgPending,
`ifdef LAYER_SOLO_EN
    input  logic                            soloValid,
    input  logic [1:0]                      soloLayer,
`endif
    output logic [7:0]                      layerOrder,
    output logic [NUM_LAYERS-1:0]           layerEnable,
    output logic [$clog2(BLINK_PERIOD)-1:0] frameCount
);

    localparam int FCW = $clog2(BLINK_PERIOD);

    ctrl_state_t           state, stateNext;
    layer_order_t          shadowOrder, activeOrder, orderNext;
    logic [NUM_LAYERS-1:0] shadowEn, shadowBlink, activeEn, activeBlink;
    logic [NUM_LAYERS-1:0] enNext, blinkNext, visNext;
    logic [FCW-1:0]        fcNext;
    logic                  isValid, accept, apply, errNext, blinkOffNext;

    order_perm_check u_perm (
        .order   (cfgOrder),
        .isValid (isValid)
    );

    always_comb begin
        stateNext  = state;
        cfgReady   = 1'b0;
        cfgPending = 1'b0;
        accept     = 1'b0;
        apply      = 1'b0;
        errNext    = 1'b0;
        case (state)
            IDLE: begin
                cfgReady = 1'b1;
                if (cfgValid) begin
                    if (isValid) begin
                        accept    = 1'b1;
                        stateNext = PENDING;
                    end else begin
                        errNext = 1'b1;
                    end
                end
            end
            PENDING: begin
                cfgPending = 1'b1;
                if (startOfFrame) begin
                    apply     = 1'b1;
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Enable is built from next-state values so every output moves on the same edge.
    always_comb begin
        orderNext = apply ? shadowOrder : activeOrder;
        enNext    = apply ? shadowEn    : activeEn;
        blinkNext = apply ? shadowBlink : activeBlink;
        fcNext    = frameCount;
        if (startOfFrame)
            fcNext = (frameCount == FCW'(BLINK_PERIOD - 1)) ? '0 : frameCount + 1'b1;
        blinkOffNext = (fcNext >= FCW'(BLINK_PERIOD / 2));
        visNext      = enNext & ~(blinkNext & {NUM_LAYERS{blinkOffNext}});
`ifdef LAYER_SOLO_EN
        if (soloValid)
            visNext = NUM_LAYERS'(1) << soloLayer;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            shadowOrder <= DEFAULT_ORDER;
            shadowEn    <= '1;
            shadowBlink <= '0;
            activeOrder <= DEFAULT_ORDER;
            activeEn    <= '1;
            activeBlink <= '0;
            frameCount  <= '0;
            cfgError    <= 1'b0;
            layerEnable <= '1;
        end else begin
            state       <= stateNext;
            cfgError    <= errNext;
            if (accept) begin
                shadowOrder <= cfgOrder;
                shadowEn    <= cfgEnableMask;
                shadowBlink <= cfgBlinkMask;
            end
            activeOrder <= orderNext;
            activeEn    <= enNext;
            activeBlink <= blinkNext;
            frameCount  <= fcNext;
            layerEnable <= visNext;
        end
    end

    assign layerOrder = activeOrder;

endmodule

// File: tb/tb_layer_priority_ctrl.sv
// Directed + random bench for layer_priority_ctrl against a frame-level reference model.
module tb_layer_priority_ctrl;

    localparam int BP = 16;
    localparam logic [7:0] DEF = 8'b11_10_01_00;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       startOfFrame = 1'b0;
    logic       cfgValid = 1'b0;
    logic       cfgReady;
    logic [7:0] cfgOrder = 8'h0;
    logic [3:0] cfgEnableMask = 4'h0;
    logic [3:0] cfgBlinkMask = 4'h0;
    logic       cfgError;
    logic       cfgPending;
    logic [7:0] layerOrder;
    logic [3:0] layerEnable;
    logic [3:0] frameCount;

    int checks = 0;
    int fails  = 0;

    // reference model state
    logic       mPend = 1'b0;
    logic       mErr = 1'b0;
    logic [7:0] mOrder = DEF, sOrder = DEF;
    logic [3:0] mEn = 4'hF, mBlink = 4'h0, sEn = 4'hF, sBlink = 4'h0;
    int         mFc = 0;

    layer_priority_ctrl #(.BLINK_PERIOD(BP)) dut (
        .clk           (clk),
        .reset         (reset),
        .startOfFrame  (startOfFrame),
        .cfgValid      (cfgValid),
        .cfgReady      (cfgReady),
        .cfgOrder      (cfgOrder),
        .cfgEnableMask (cfgEnableMask),
        .cfgBlinkMask  (cfgBlinkMask),
        .cfgError      (cfgError),
        .cfgPending    (cfgPending),
`ifdef LAYER_SOLO_EN
        .soloValid     (1'b0),
        .soloLayer     (2'd0),
`endif
        .layerOrder    (layerOrder),
        .layerEnable   (layerEnable),
        .frameCount    (frameCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Each layer index 0..3 must appear in exactly one slot.
    function automatic logic is_perm(input logic [7:0] o);
        logic ok = 1'b1;
        for (int v = 0; v < 4; v++) begin
            int c = 0;
            for (int s = 0; s < 4; s++)
                if (o[2*s +: 2] == v[1:0]) c++;
            if (c != 1) ok = 1'b0;
        end
        return ok;
    endfunction

    function automatic logic [3:0] exp_enable();
        logic [3:0] off = (mFc >= BP / 2) ? mBlink : 4'h0;
        return mEn & ~off;
    endfunction

    task automatic step(input logic sof, input logic v, input logic [7:0] o,
                        input logic [3:0] e, input logic [3:0] b, input logic rst);
        logic wasPend;
        @(negedge clk);
        reset = rst; startOfFrame = sof; cfgValid = v;
        cfgOrder = o; cfgEnableMask = e; cfgBlinkMask = b;
        @(posedge clk);
        if (rst) begin
            mPend = 1'b0; mErr = 1'b0; mOrder = DEF; mEn = 4'hF; mBlink = 4'h0; mFc = 0;
        end else begin
            mErr = 1'b0;
            wasPend = mPend;
            if (!wasPend) begin
                if (v) begin
                    if (is_perm(o)) begin
                        sOrder = o; sEn = e; sBlink = b; mPend = 1'b1;
                    end else begin
                        mErr = 1'b1;
                    end
                end
            end else if (sof) begin
                mOrder = sOrder; mEn = sEn; mBlink = sBlink; mPend = 1'b0;
            end
            if (sof) mFc = (mFc + 1) % BP;
        end
        #1;
        chk("cfgReady",    cfgReady,    !mPend);
        chk("cfgPending",  cfgPending,  mPend);
        chk("cfgError",    cfgError,    mErr);
        chk("layerOrder",  layerOrder,  mOrder);
        chk("layerEnable", layerEnable, exp_enable());
        chk("frameCount",  frameCount,  mFc);
    endtask

    task automatic idle(input logic sof);
        step(sof, 1'b0, 8'h00, 4'h0, 4'h0, 1'b0);
    endtask

    initial begin
        logic [1:0] p [4];
        logic [7:0] o;

        // reset for three cycles
        repeat (3) step(1'b0, 1'b0, 8'h00, 4'h0, 4'h0, 1'b1);
        chk("rst_order",  layerOrder,  8'hE4);
        chk("rst_enable", layerEnable, 4'hF);
        chk("rst_ready",  cfgReady,    1'b1);
        chk("rst_fc",     frameCount,  4'd0);

        // apply a reversed order at the next frame boundary
        step(1'b0, 1'b1, 8'b00_01_10_11, 4'hF, 4'h0, 1'b0);
        chk("apply_pending", cfgPending, 1'b1);
        idle(1'b0);
        idle(1'b0);
        chk("apply_hold", layerOrder, 8'hE4);
        idle(1'b1);
        chk("apply_order", layerOrder, 8'h1B);
        chk("apply_ready", cfgReady, 1'b1);

        // reject a duplicate-index order
        step(1'b0, 1'b1, 8'b00_00_10_11, 4'h3, 4'h0, 1'b0);
        chk("reject_err", cfgError, 1'b1);
        chk("reject_idle", cfgReady, 1'b1);
        idle(1'b1);
        chk("reject_pulse", cfgError, 1'b0);
        chk("reject_order", layerOrder, 8'h1B);

        // blink layer 1 over a full blink period
        step(1'b0, 1'b1, 8'hE4, 4'hF, 4'b0010, 1'b0);
        idle(1'b1);
        for (int f = 0; f < BP + 2; f++) begin
            idle(1'b0);
            idle(1'b1);
            chk("blink_l1", layerEnable[1], (frameCount < 4'd8));
            chk("blink_l0", layerEnable[0], 1'b1);
        end
        while (frameCount != 4'd15) idle(1'b1);
        idle(1'b1);
        chk("fc_wrap", frameCount, 4'd0);

        // config accepted together with startOfFrame waits one more frame
        step(1'b1, 1'b1, 8'b01_00_11_10, 4'h5, 4'h0, 1'b0);
        chk("coll_hold", layerOrder, 8'hE4);
        chk("coll_pending", cfgPending, 1'b1);
        idle(1'b0);
        idle(1'b1);
        chk("coll_apply", layerOrder, 8'h4E);
        chk("coll_enable", layerEnable, 4'h5);

        // reset while pending discards the shadow
        step(1'b0, 1'b1, 8'h1B, 4'h1, 4'h0, 1'b0);
        step(1'b0, 1'b0, 8'h00, 4'h0, 4'h0, 1'b1);
        idle(1'b1);
        chk("rstpend_order", layerOrder, 8'hE4);
        chk("rstpend_enable", layerEnable, 4'hF);
        chk("rstpend_ready", cfgReady, 1'b1);

        // random traffic
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(1) == 1) begin
                p[0] = 2'd0; p[1] = 2'd1; p[2] = 2'd2; p[3] = 2'd3;
                for (int i = 3; i > 0; i--) begin
                    int j = $urandom_range(i);
                    logic [1:0] t = p[i];
                    p[i] = p[j]; p[j] = t;
                end
                o = {p[3], p[2], p[1], p[0]};
            end else begin
                o = 8'($urandom);
            end
            step(($urandom_range(5) == 0), ($urandom_range(2) == 0), o,
                 4'($urandom), 4'($urandom), ($urandom_range(120) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
